// File: rtl/sw_debounce_toggle_if.sv
// Switch front-end bundle: raw switch/mode/clear in,
// debounced state, edge pulses and LED drive out.
interface sw_debounce_toggle_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0]   i_sw_n;
  logic [2*N_CH-1:0] i_mode;
  logic              i_tog_clr;
  logic [N_CH-1:0]   o_state;
  logic [N_CH-1:0]   o_press;
  logic [N_CH-1:0]   o_release;
  logic [N_CH-1:0]   o_led;

  modport master (
    output i_sw_n,
    output i_mode,
    output i_tog_clr,
    input  o_state,
    input  o_press,
    input  o_release,
    input  o_led
  );

  modport slave (
    input  i_sw_n,
    input  i_mode,
    input  i_tog_clr,
    output o_state,
    output o_press,
    output o_release,
    output o_led
  );
endinterface

// File: rtl/sw_debounce_toggle.sv
// N-channel active-low switch front end: sync, debounce,
// edge pulses and per-channel LED mode (level/toggle/flash).
module sw_debounce_toggle #(
  parameter int N_CH      = 4,
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  sw_debounce_toggle_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_CH-1:0]  d1;
  logic [N_CH-1:0]  d2;
  logic [N_CH-1:0]  raw;
  logic [N_CH-1:0]  flip;
  logic [N_CH-1:0]  tog_ev;
  logic [N_CH-1:0]  state;
  logic [N_CH-1:0]  press;
  logic [N_CH-1:0]  rel;
  logic [N_CH-1:0]  tog;
  logic [N_CH-1:0]  led;
  logic [CNT_W-1:0] cnt  [N_CH];
  logic [1:0]       mode [N_CH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      d1 <= '1;
      d2 <= '1;
    end else begin
      d1 <= bus.i_sw_n;
      d2 <= d1;
    end
  end

  // flip: raw has differed from state long enough
  always_comb begin
    raw = ~d2;
    for (int c = 0; c < N_CH; c++) begin
      mode[c]   = bus.i_mode[2*c +: 2];
      flip[c]   = (raw[c] != state[c]) &&
                  (cnt[c] == CNT_MAX);
      tog_ev[c] = flip[c] &&
                  ((mode[c] == 2'b01 && raw[c]) ||
                   (mode[c] == 2'b10 && !raw[c]));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < N_CH; c++) cnt[c] <= '0;
      state <= '0;
      press <= '0;
      rel   <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (raw[c] == state[c] || flip[c])
          cnt[c] <= '0;
        else
          cnt[c] <= cnt[c] + CNT_ONE;
      end
      state <= state ^ flip;
      press <= flip & raw;
      rel   <= flip & ~raw;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      tog <= '0;
    else if (bus.i_tog_clr)
      tog <= '0;
    else
      tog <= tog ^ tog_ev;
  end

  always_comb begin
    led = '0;
    for (int c = 0; c < N_CH; c++) begin
      unique case (1'b1)
        mode[c] == 2'b00: led[c] = state[c];
        mode[c] == 2'b11: led[c] = press[c];
        default:          led[c] = tog[c];
      endcase
    end
  end

  assign bus.o_state   = state;
  assign bus.o_press   = press;
  assign bus.o_release = rel;
  assign bus.o_led     = led;
endmodule

// File: tb/tb_sw_debounce_toggle.sv
// Scoreboard bench: behavioural switch model pushes expected
// outputs each edge; popped and compared on the falling edge.
module tb_sw_debounce_toggle;
  localparam int N  = 4;
  localparam int DB = 4;
  localparam int CW = 3;

  typedef struct packed {
    logic [N-1:0] st;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
    logic [N-1:0] led;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sw_debounce_toggle_if #(.N_CH(N)) bus ();

  sw_debounce_toggle #(
    .N_CH(N),
    .DB_CYCLES(DB),
    .CNT_W(CW)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  obs_t sb [$];

  logic [N-1:0] m_d1, m_d2, m_st, m_pr, m_rl, m_tog;
  int           m_run [N];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d1 = '1; m_d2 = '1;
    m_st = '0; m_pr = '0; m_rl = '0; m_tog = '0;
    for (int c = 0; c < N; c++) m_run[c] = 0;
    sb.delete();
  endtask

  function automatic logic [N-1:0] m_led();
    logic [N-1:0] l;
    logic [1:0]   md;
    l = '0;
    for (int c = 0; c < N; c++) begin
      md = bus.i_mode[2*c +: 2];
      case (md)
        2'b00:   l[c] = m_st[c];
        2'b11:   l[c] = m_pr[c];
        default: l[c] = m_tog[c];
      endcase
    end
    return l;
  endfunction

  // One clock edge of the behavioural switch model
  task automatic model_edge();
    logic       pressed;
    logic [1:0] md;
    for (int c = 0; c < N; c++) begin
      pressed  = ~m_d2[c];
      m_pr[c]  = 1'b0;
      m_rl[c]  = 1'b0;
      md       = bus.i_mode[2*c +: 2];
      if (pressed != m_st[c]) begin
        m_run[c]++;
        if (m_run[c] == DB) begin
          m_st[c]  = pressed;
          m_run[c] = 0;
          m_pr[c]  = pressed;
          m_rl[c]  = ~pressed;
        end
      end else begin
        m_run[c] = 0;
      end
      if (bus.i_tog_clr)
        m_tog[c] = 1'b0;
      else if ((md == 2'b01 && m_pr[c]) ||
               (md == 2'b10 && m_rl[c]))
        m_tog[c] = ~m_tog[c];
    end
    m_d2 = m_d1;
    m_d1 = bus.i_sw_n;
  endtask

  task automatic step();
    obs_t e;
    @(posedge clk);
    model_edge();
    e.st  = m_st;
    e.pr  = m_pr;
    e.rl  = m_rl;
    e.led = m_led();
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check("state",   32'(bus.o_state),   32'(e.st));
    check("press",   32'(bus.o_press),   32'(e.pr));
    check("release", 32'(bus.o_release), 32'(e.rl));
    check("led",     32'(bus.o_led),     32'(e.led));
    check("excl", 32'(bus.o_press & bus.o_release), 0);
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  // Steps until a press/release pulse on ch; 99 on timeout
  task automatic wait_bit(input int ch, input bit rel,
                          output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      step();
      if ((rel ? bus.o_release[ch] : bus.o_press[ch])
          === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic set_sw(input int ch, input logic v);
    logic [N-1:0] s;
    s        = bus.i_sw_n;
    s[ch]    = v;
    bus.i_sw_n = s;
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_st"},  32'(bus.o_state),   0);
    check({tag, "_pr"},  32'(bus.o_press),   0);
    check({tag, "_rl"},  32'(bus.o_release), 0);
    check({tag, "_led"}, 32'(bus.o_led),     0);
  endtask

  initial begin
    int n;
    bus.i_sw_n    = '1;
    bus.i_mode    = '0;
    bus.i_tog_clr = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 all_zero("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    steps(20);

    set_sw(0, 1'b0);
    wait_bit(0, 1'b0, n);
    check("lat_press0", n, DB + 2);
    steps(2);
    check("led0_lvl", 32'(bus.o_led[0]), 1);
    set_sw(0, 1'b1);
    wait_bit(0, 1'b1, n);
    check("lat_rel0", n, DB + 2);
    steps(2);
    check("led0_off", 32'(bus.o_led[0]), 0);

    set_sw(1, 1'b0); steps(3);
    set_sw(1, 1'b1); steps(1);
    set_sw(1, 1'b0);
    wait_bit(1, 1'b0, n);
    check("lat_bounce1", n, DB + 2);
    steps(3);
    set_sw(1, 1'b1);
    wait_bit(1, 1'b1, n);
    steps(2);

    bus.i_mode = 8'h10;
    for (int i = 0; i < 3; i++) begin
      set_sw(2, 1'b0);
      wait_bit(2, 1'b0, n);
      steps(2);
      check("tog_press2", 32'(bus.o_led[2]),
            32'((i % 2) == 0));
      set_sw(2, 1'b1);
      wait_bit(2, 1'b1, n);
      steps(2);
    end

    bus.i_mode = 8'h90;
    for (int i = 0; i < 2; i++) begin
      set_sw(3, 1'b0);
      wait_bit(3, 1'b0, n);
      steps(2);
      check("tog_p3", 32'(bus.o_led[3]), 32'(i % 2));
      set_sw(3, 1'b1);
      wait_bit(3, 1'b1, n);
      steps(2);
      check("tog_r3", 32'(bus.o_led[3]),
            32'((i % 2) == 0));
    end

    bus.i_tog_clr = 1'b1; step();
    bus.i_tog_clr = 1'b0; step();
    check("clr2", 32'(bus.o_led[2]), 0);
    set_sw(2, 1'b0);
    steps(DB + 1);
    bus.i_tog_clr = 1'b1; step();
    check("clr_ev_pr", 32'(bus.o_press[2]), 1);
    bus.i_tog_clr = 1'b0; steps(2);
    check("clr_wins", 32'(bus.o_led[2]), 0);
    set_sw(2, 1'b1);
    wait_bit(2, 1'b1, n);
    steps(2);

    bus.i_mode = 8'h93;
    set_sw(0, 1'b0);
    wait_bit(0, 1'b0, n);
    check("flash_on", 32'(bus.o_led[0]), 1);
    step();
    check("flash_off", 32'(bus.o_led[0]), 0);
    set_sw(0, 1'b1);
    wait_bit(0, 1'b1, n);
    steps(2);

    set_sw(1, 1'b0);
    steps(4);
    rst_n = 1'b0;
    #1 all_zero("midrst");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    all_zero("inrst");
    rst_n = 1'b1;
    wait_bit(1, 1'b0, n);
    check("rst_lat1", n, DB + 2);
    steps(3);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
